// File: rtl/counter_cmd_seq.sv
// Command sequencer for the 4-bit load/rotate/count-up counter stage; drives its controls and reports result/wraps.
// Optional: define COUNTER_CMD_SEQ_ABORT_EN to add cmd_abort, which ends a RUN early.
module counter_cmd_seq #(
  parameter int DATA_W = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
`ifdef COUNTER_CMD_SEQ_ABORT_EN
  input  logic              cmd_abort,
`endif
  output logic              ctr_reset_n,
  output logic              ctr_load_n,
  output logic              ctr_mode,
  output logic [DATA_W-1:0] ctr_data,
  input  logic [DATA_W-1:0] ctr_q,
  input  logic              ctr_rco,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [STEP_W-1:0] wrap_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_COUNT  = 2'b10;

  state_t              state, state_nxt;
  logic [1:0]          op_lat;
  logic [DATA_W-1:0]   data_lat;
  logic [STEP_W-1:0]   steps_left;
  logic [DATA_W-1:0]   hold_reg;
  logic                accept;
  logic                run_end;

  assign accept = cmd_valid && (state == S_IDLE);

`ifdef COUNTER_CMD_SEQ_ABORT_EN
  assign run_end = (steps_left == STEP_W'(1)) || cmd_abort;
`else
  assign run_end = (steps_left == STEP_W'(1));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: state_nxt = S_CLEAR;
            OP_LOAD:  state_nxt = S_LOAD;
            default:  state_nxt = (cmd_steps == '0) ? S_DONE : S_RUN;
          endcase
        end
      end
      S_CLEAR: state_nxt = S_DONE;
      S_LOAD:  state_nxt = S_DONE;
      S_RUN:   if (run_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_lat     <= OP_CLEAR;
      data_lat   <= '0;
      steps_left <= '0;
      wrap_cnt   <= '0;
      result     <= '0;
      hold_reg   <= '0;
    end else begin
      if (accept) begin
        op_lat     <= cmd_op;
        data_lat   <= cmd_data;
        steps_left <= cmd_steps;
        wrap_cnt   <= '0;
      end
      if (state == S_RUN) begin
        steps_left <= steps_left - STEP_W'(1);
        // RCO high on a counting edge means the counter wraps to zero on that edge
        if ((op_lat == OP_COUNT) && ctr_rco && (wrap_cnt != '1))
          wrap_cnt <= wrap_cnt + STEP_W'(1);
      end
      if (state == S_DONE) begin
        hold_reg <= ctr_q;
        result   <= ctr_q;
      end
    end
  end

  // Counter has no enable: every non-run state reloads a value to keep it still.
  always_comb begin
    ctr_reset_n = 1'b1;
    ctr_load_n  = 1'b0;
    ctr_mode    = 1'b1;
    ctr_data    = hold_reg;
    case (state)
      S_CLEAR: begin
        ctr_reset_n = 1'b0;
        ctr_load_n  = 1'b1;
      end
      S_LOAD:  ctr_data = data_lat;
      S_RUN: begin
        ctr_load_n = 1'b1;
        ctr_mode   = (op_lat == OP_COUNT);
      end
      S_DONE:  ctr_data = ctr_q;
      default: ;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
- Command sequencer directly upstream of the 4-bit load/rotate/count-up counter stage.
- Accepts commands over a valid/ready handshake and drives the counter's active-low reset, active-low Load, mode and data_in for the required number of cycles.
- Watches the counter's data_out and RCO, and reports the final value plus a wrap count.
- The counter has no enable, so this block holds it between commands by reloading its own value each cycle.

Parameters:
- DATA_W, 4, counter data width (ctr_data, ctr_q, cmd_data, result).
- STEP_W, 8, width of the step count and of wrap_cnt.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_op  input  2  00 CLEAR, 01 LOAD, 10 COUNT (up), 11 ROTATE (left).
- cmd_data  input  DATA_W  load value for LOAD.
- cmd_steps  input  STEP_W  cycles to run for COUNT/ROTATE.
- ctr_reset_n  output  1  to counter reset (active low).
- ctr_load_n  output  1  to counter Load (active low).
- ctr_mode  output  1  to counter mode (0 rotate, 1 count).
- ctr_data  output  DATA_W  to counter data_in.
- ctr_q  input  DATA_W  from counter data_out.
- ctr_rco  input  1  from counter RCO (high when ctr_q == all ones).
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when a command completes.
- result  output  DATA_W  counter value captured at completion.
- wrap_cnt  output  STEP_W  count of wraps during the last COUNT command; saturating.

Behaviour:
- Reset (asynchronous, active-high) sets these values:
  - State = IDLE.
  - cmd_ready = 1, busy = 0, done = 0.
  - result = 0, wrap_cnt = 0, hold_reg = 0.
  - ctr_reset_n = 1, ctr_load_n = 0, ctr_mode = 1, ctr_data = 0.
- All outputs are registered or decoded from state/registers only; there is no combinational path from cmd_* to ctr_*.
- Handshake: a command is accepted on a clock edge where cmd_valid & cmd_ready. The block latches op, data and steps, clears wrap_cnt and moves to the op state. cmd_ready drops the next cycle.
- IDLE:
  - ctr_load_n = 0 and ctr_data = hold_reg, so the counter reloads itself and holds its value.
  - ctr_reset_n = 1.
- CLEAR: one cycle with ctr_reset_n = 0 and ctr_load_n = 1, then DONE.
- LOAD: one cycle with ctr_load_n = 0 and ctr_data = latched cmd_data, then DONE.
- RUN (COUNT/ROTATE):
  - ctr_load_n = 1; ctr_mode = 1 for COUNT, 0 for ROTATE.
  - Lasts exactly cmd_steps cycles, tracked by a down-counter, then DONE.
  - If cmd_steps == 0, RUN is skipped: go straight to DONE and the counter value is unchanged.
- Wrap counting:
  - Applies to COUNT only.
  - Every RUN cycle with ctr_rco = 1 increments wrap_cnt, because the counter goes all-ones -> 0 on that edge.
  - wrap_cnt saturates at 2^STEP_W-1.
  - In ROTATE, wrap_cnt stays 0.
- DONE (one cycle):
  - ctr_load_n = 0 and ctr_data = ctr_q (hold).
  - hold_reg <= ctr_q and result <= ctr_q.
  - done = 1 for this cycle only, then IDLE.
- Latency from accept to done pulse:
  - CLEAR and LOAD: 2 cycles.
  - COUNT/ROTATE: cmd_steps + 1 cycles.
- Back-to-back: a new command may be accepted in the cycle after done (IDLE). cmd_valid held high while busy is ignored; no command is lost or queued.
- cmd_op is fully decoded; there is no illegal op.
- Reset mid-command: the block returns to IDLE immediately, drops busy and produces no done pulse. The counter is not reset by this block unless CLEAR is issued.

Optional Feature:
- Macro: COUNTER_CMD_SEQ_ABORT_EN.
- When defined:
  - Adds input cmd_abort (1 bit).
  - cmd_abort = 1 in RUN terminates RUN at the next edge and enters DONE. The result and wrap count reflect the cycles actually run.
  - cmd_abort is ignored in all other states.
- When undefined: the port is absent and RUN always runs the full cmd_steps.

Test Plan:
- Reset, then LOAD cmd_data=4'h3 -> ctr_load_n low for one cycle with ctr_data=3. done after 2 cycles; result=3. Counter stays 3 for 10 idle cycles.
- LOAD 4'hE, then COUNT steps=5 -> counter sequence E,F,0,1,2,3. done at accept+6; result=3, wrap_cnt=1.
- LOAD 4'h1, then ROTATE steps=3 -> counter sequence 1,2,4,8. result=8, wrap_cnt=0.
- COUNT steps=0 from value 7 -> done at accept+1; result=7; ctr_load_n never goes high.
- COUNT steps=40 from 0 -> result=8, wrap_cnt=2. Reset asserted mid-RUN returns the block to IDLE with no done pulse.
- With COUNTER_CMD_SEQ_ABORT_EN: COUNT steps=100 from 0, cmd_abort pulsed on the 4th RUN cycle -> result=4, done pulse, back to IDLE.
